instr_byte_fifo: RTL



---
 rtl/instr_byte_fifo_if.sv | 21 ++
 rtl/instr_byte_fifo.sv | 105 ++++++++++
 2 files changed

// File: rtl/instr_byte_fifo_if.sv
// Byte-in / word-out handshake bundle for the instruction byte FIFO.
// master: pad-side feeder plus core load port (drives bytes, consumes words).
// slave:  the FIFO itself.
interface instr_byte_fifo_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output byte_in, byte_valid, instr_ready,
    input  byte_ready, instr_out, instr_valid
  );

  modport slave (
    input  byte_in, byte_valid, instr_ready,
    output byte_ready, instr_out, instr_valid
  );
endinterface

// File: rtl/instr_byte_fifo.sv
// Instruction byte FIFO: assembles pad bytes (low first) into 16-bit words and
// buffers them for the execute core's instruction-load port.
//
// state | meaning
// ------+---------------------------------------------------------------
// LO    | waiting for the low byte of the next word
// HI    | low byte held in low_hold, waiting for the high byte
//
// A low byte is accepted even when the FIFO is full; only the high byte
// (the actual write) stalls. byte_ready depends on registered state only.
module instr_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  instr_byte_fifo_if.slave bus,
  output logic [LVL_W-1:0] level,
  output logic             half_pending
);

  localparam int AW = LVL_W - 1;

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } asm_state_t;

  asm_state_t       state;
  asm_state_t       state_nxt;
  logic [7:0]       low_hold;
  logic [15:0]      mem [DEPTH];
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             byte_ready;
  logic             byte_acc;
  logic             push;
  logic             pop;
  logic             half_c;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign byte_ready = (state == LO) || !full;
  assign byte_acc   = bus.byte_valid && byte_ready;
  // flush wins over any same-cycle push or pop
  assign push       = byte_acc && (state == HI) && !flush;
  assign pop        = !empty && bus.instr_ready && !flush;

  assign bus.byte_ready  = byte_ready;
  assign bus.instr_valid = !empty;
  assign bus.instr_out   = empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];
  assign level           = wr_ptr - rd_ptr;
  assign half_pending    = half_c;

  // Assembler state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LO;
    else        state <= state_nxt;
  end

  // Assembler next-state and status output
  always_comb begin
    state_nxt = state;
    half_c    = 1'b0;
    unique case (state)
      LO: if (byte_acc) state_nxt = HI;
      HI: begin
        half_c = 1'b1;
        if (byte_acc) state_nxt = LO;
      end
      default: state_nxt = LO;
    endcase
    if (flush) state_nxt = LO;
  end

  // Low-byte holding register; a partial word is simply abandoned on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   low_hold <= 8'h00;
    else if (byte_acc && (state == LO) && !flush) low_hold <= bus.byte_in;
  end

  // Word storage, no reset needed since instr_out is masked when empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.byte_in, low_hold};
  end

  // Read/write pointers with one extra wrap bit for full/empty detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LVL_W'(1);
      if (pop)  rd_ptr <= rd_ptr + LVL_W'(1);
    end
  end

endmodule
